// File: rtl/excp_pc_seq_pkg.sv
// Shared encodings for the exception / PC-update sequencer.
// Latency: n/a (constants, types and a pure priority function only).
// Backpressure: n/a.
//
// Holds the PCSrc, JumpKind, cause and FSM state encodings, the default vector
// base address and the exception priority encoder used by excp_pc_seq.
package excp_pc_seq_pkg;

    // Next-PC source selection
    localparam logic [2:0] PCSRC_REGA       = 3'd0;
    localparam logic [2:0] PCSRC_ALURESULT  = 3'd1;
    localparam logic [2:0] PCSRC_INCONDJUMP = 3'd2;
    localparam logic [2:0] PCSRC_ALUOUT     = 3'd3;
    localparam logic [2:0] PCSRC_EPC        = 3'd4;
    localparam logic [2:0] PCSRC_EXCPCODE   = 3'd5;

    // PC update request kinds; 6 and 7 behave like JK_NONE
    localparam logic [2:0] JK_NONE   = 3'd0;
    localparam logic [2:0] JK_JR     = 3'd1;
    localparam logic [2:0] JK_SEQ    = 3'd2;
    localparam logic [2:0] JK_BRANCH = 3'd3;
    localparam logic [2:0] JK_JUMP   = 3'd4;
    localparam logic [2:0] JK_RTE    = 3'd5;

    // Exception causes; the value minus one is the offset into the vector table
    typedef logic [1:0] cause_t;
    localparam cause_t CAUSE_NONE     = 2'd0;
    localparam cause_t CAUSE_OPCODE   = 2'd1;
    localparam cause_t CAUSE_OVERFLOW = 2'd2;
    localparam cause_t CAUSE_DIV0     = 2'd3;

    localparam logic [31:0] VEC_BASE_DEFAULT    = 32'd253;
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 16;

    // FSM state encoding
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE      = 2'd0;
    localparam fsm_state_t ST_SAVE_EPC  = 2'd1;
    localparam fsm_state_t ST_FETCH_VEC = 2'd2;
    localparam fsm_state_t ST_LOAD_PC   = 2'd3;

    // Priority: InvalidOpcode > Overflow > DivByZero
    function automatic cause_t excp_cause(input logic inv, input logic ovf, input logic dz);
        cause_t c;
        if (inv)      c = CAUSE_OPCODE;
        else if (ovf) c = CAUSE_OVERFLOW;
        else if (dz)  c = CAUSE_DIV0;
        else          c = CAUSE_NONE;
        return c;
    endfunction

endpackage

// File: rtl/excp_pc_seq_if.sv
// Bundle of request, memory and strobe signals around the PC sequencer.
// Latency: n/a (wiring only).
// Backpressure: MemAck is the only flow control; the sequencer waits on it.
//
// master: the surrounding datapath/controller (drives requests and memory data)
// slave : excp_pc_seq (drives PC selection, strobes and status)
interface excp_pc_seq_if;
    logic [2:0]  JumpKind;
    logic        BranchTaken;
    logic        InvalidOpcode;
    logic        Overflow;
    logic        DivByZero;
    logic [7:0]  MemData;
    logic        MemAck;

    logic [2:0]  PCSrc;
    logic        PCWrite;
    logic        EPCWrite;
    logic        MemRead;
    logic [31:0] ExcpAddr;
    logic [31:0] ExcpCode;
    logic        Busy;
    logic [1:0]  ExcpCause;
    logic        ExcpErr;

    modport master (
        output JumpKind, BranchTaken, InvalidOpcode, Overflow, DivByZero, MemData, MemAck,
        input  PCSrc, PCWrite, EPCWrite, MemRead, ExcpAddr, ExcpCode, Busy, ExcpCause, ExcpErr
    );

    modport slave (
        input  JumpKind, BranchTaken, InvalidOpcode, Overflow, DivByZero, MemData, MemAck,
        output PCSrc, PCWrite, EPCWrite, MemRead, ExcpAddr, ExcpCode, Busy, ExcpCause, ExcpErr
    );
endinterface

// File: rtl/excp_pc_seq.sv
// PC-source selector with an exception entry sequence (save EPC, fetch vector, load PC).
// Latency: jumps are combinational in IDLE; exception-to-PC-load is 3 cycles plus MemAck wait.
// Backpressure: stalls in FETCH_VEC until MemAck; requests arriving while Busy are ignored.
//
// Ports: clk, reset_n (async active-low); bus (excp_pc_seq_if.slave):
//   in : JumpKind[2:0], BranchTaken, InvalidOpcode, Overflow, DivByZero, MemData[7:0], MemAck
//   out: PCSrc[2:0], PCWrite, EPCWrite, MemRead, ExcpAddr[31:0], ExcpCode[31:0], Busy,
//        ExcpCause[1:0], ExcpErr
// Optional: define EXCP_TIMEOUT_EN to abandon FETCH_VEC after TIMEOUT_CYC cycles without
// MemAck and raise the sticky ExcpErr flag. Undefined, FETCH_VEC waits forever.
module excp_pc_seq
    import excp_pc_seq_pkg::*;
#(
    parameter logic [31:0] VEC_BASE    = VEC_BASE_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    excp_pc_seq_if.slave bus
);

    // A zero timeout would make the wait limit meaningless.
    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("excp_pc_seq: TIMEOUT_CYC must be nonzero");
    end

    fsm_state_t state_q;
    fsm_state_t state_d;
    cause_t     cause_q;
    logic [7:0] code_q;
    logic [2:0] pcsrc_q;

    logic [2:0]  pcsrc;
    logic        pcwrite;
    logic        epcwrite;
    logic        memread;
    logic [31:0] excp_addr;
    logic        accept;
    logic        any_excp;
    logic        timeout_hit;

    assign any_excp = bus.InvalidOpcode | bus.Overflow | bus.DivByZero;

`ifdef EXCP_TIMEOUT_EN
    // Counts cycles spent in FETCH_VEC; cleared in every other state.
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;

    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == ST_FETCH_VEC) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end else begin
                to_cnt_q <= '0;
            end
            if (state_q == ST_FETCH_VEC && !bus.MemAck && timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.ExcpErr = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.ExcpErr = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pcsrc     = pcsrc_q;   // unselected cycles keep the last driven selection
        pcwrite   = 1'b0;
        epcwrite  = 1'b0;
        memread   = 1'b0;
        excp_addr = 32'd0;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_excp) begin
                    // Exception beats any jump requested in the same cycle
                    accept  = 1'b1;
                    state_d = ST_SAVE_EPC;
                end else begin
                    case (bus.JumpKind)
                        JK_JR: begin
                            pcsrc   = PCSRC_REGA;
                            pcwrite = 1'b1;
                        end
                        JK_SEQ: begin
                            pcsrc   = PCSRC_ALURESULT;
                            pcwrite = 1'b1;
                        end
                        JK_BRANCH: begin
                            pcsrc   = PCSRC_ALUOUT;
                            pcwrite = bus.BranchTaken;
                        end
                        JK_JUMP: begin
                            pcsrc   = PCSRC_INCONDJUMP;
                            pcwrite = 1'b1;
                        end
                        JK_RTE: begin
                            pcsrc   = PCSRC_EPC;
                            pcwrite = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            ST_SAVE_EPC: begin
                epcwrite = 1'b1;
                state_d  = ST_FETCH_VEC;
            end

            ST_FETCH_VEC: begin
                memread   = 1'b1;
                excp_addr = VEC_BASE + 32'(cause_q) - 32'd1;
                if (bus.MemAck) begin
                    state_d = ST_LOAD_PC;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOAD_PC: begin
                pcsrc   = PCSRC_EXCPCODE;
                pcwrite = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
            code_q  <= 8'd0;
            pcsrc_q <= PCSRC_REGA;
        end else begin
            state_q <= state_d;
            pcsrc_q <= pcsrc;
            if (accept) begin
                cause_q <= excp_cause(bus.InvalidOpcode, bus.Overflow, bus.DivByZero);
            end
            if (state_q == ST_FETCH_VEC && bus.MemAck) begin
                code_q <= bus.MemData;
            end
        end
    end

    assign bus.PCSrc     = pcsrc;
    assign bus.PCWrite   = pcwrite;
    assign bus.EPCWrite  = epcwrite;
    assign bus.MemRead   = memread;
    assign bus.ExcpAddr  = excp_addr;
    assign bus.ExcpCode  = {24'd0, code_q};
    assign bus.Busy      = (state_q != ST_IDLE);
    assign bus.ExcpCause = cause_q;

endmodule

// File: tb/tb_excp_pc_seq.sv
// Self-checking bench for excp_pc_seq: jump decode table, exception corner sequences,
// reset abort, optional timeout, and a randomized run against a cycle-age reference model.
module tb_excp_pc_seq;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    excp_pc_seq_if bus();

    excp_pc_seq #(
        .VEC_BASE    (32'd253),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] jk;
        logic       bt;
        logic [2:0] pcsrc;
        logic       pw;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge, outputs sampled 4 after.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive_idle();
        bus.JumpKind      = 3'd0;
        bus.BranchTaken   = 1'b0;
        bus.InvalidOpcode = 1'b0;
        bus.Overflow      = 1'b0;
        bus.DivByZero     = 1'b0;
        bus.MemData       = 8'd0;
        bus.MemAck        = 1'b0;
    endtask

    function automatic logic [127:0] all_outs();
        return {bus.PCSrc, bus.PCWrite, bus.EPCWrite, bus.MemRead, bus.ExcpAddr,
                bus.ExcpCode, bus.Busy, bus.ExcpCause, bus.ExcpErr};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #2;
        chk("reset outputs", all_outs(), 128'd0);
        next_cycle();
        reset_n = 1'b1;
    endtask

    // Reference model: tracks how many cycles ago the exception was taken
    function automatic logic [1:0] prio(input logic inv, input logic ovf, input logic dz);
        if (inv) return 2'd1;
        if (ovf) return 2'd2;
        if (dz)  return 2'd3;
        return 2'd0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        reset_n = 1'b1;
        #2;
        do_reset();

        // ---------------- jump decode table (IDLE, no exceptions) ----------------
        // kind 0/6/7 rows expect the selection driven on the previous row
        tbl[0]  = '{3'd1, 1'b0, 3'd0, 1'b1};
        tbl[1]  = '{3'd2, 1'b0, 3'd1, 1'b1};
        tbl[2]  = '{3'd3, 1'b0, 3'd3, 1'b0};
        tbl[3]  = '{3'd3, 1'b1, 3'd3, 1'b1};
        tbl[4]  = '{3'd0, 1'b1, 3'd3, 1'b0};
        tbl[5]  = '{3'd4, 1'b0, 3'd2, 1'b1};
        tbl[6]  = '{3'd6, 1'b1, 3'd2, 1'b0};
        tbl[7]  = '{3'd5, 1'b0, 3'd4, 1'b1};
        tbl[8]  = '{3'd7, 1'b0, 3'd4, 1'b0};
        tbl[9]  = '{3'd2, 1'b1, 3'd1, 1'b1};
        tbl[10] = '{3'd0, 1'b0, 3'd1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            next_cycle();
            bus.JumpKind    = tbl[i].jk;
            bus.BranchTaken = tbl[i].bt;
            settle();
            chk($sformatf("tbl%0d PCSrc", i), 128'(bus.PCSrc), 128'(tbl[i].pcsrc));
            chk($sformatf("tbl%0d PCWrite", i), 128'(bus.PCWrite), 128'(tbl[i].pw));
        end
        drive_idle();

        // ---------------- Overflow + DivByZero, immediate MemAck ----------------
        next_cycle();
        bus.Overflow = 1'b1; bus.DivByZero = 1'b1; bus.JumpKind = 3'd2;
        settle();
        chk("ovf c0 PCWrite", 128'(bus.PCWrite), 128'd0);
        chk("ovf c0 Busy", 128'(bus.Busy), 128'd0);
        next_cycle();
        drive_idle();
        settle();
        chk("ovf c1 EPCWrite", 128'(bus.EPCWrite), 128'd1);
        chk("ovf c1 ExcpCause", 128'(bus.ExcpCause), 128'd2);
        chk("ovf c1 Busy", 128'(bus.Busy), 128'd1);
        next_cycle();
        bus.MemAck = 1'b1; bus.MemData = 8'h2C;
        settle();
        chk("ovf c2 MemRead", 128'(bus.MemRead), 128'd1);
        chk("ovf c2 ExcpAddr", 128'(bus.ExcpAddr), 128'd254);
        chk("ovf c2 EPCWrite", 128'(bus.EPCWrite), 128'd0);
        next_cycle();
        drive_idle();
        settle();
        chk("ovf c3 PCSrc", 128'(bus.PCSrc), 128'd5);
        chk("ovf c3 PCWrite", 128'(bus.PCWrite), 128'd1);
        chk("ovf c3 ExcpCode", 128'(bus.ExcpCode), 128'h2C);
        next_cycle();
        bus.MemAck = 1'b1; bus.MemData = 8'h77;   // stray ack in IDLE
        settle();
        chk("ovf c4 Busy", 128'(bus.Busy), 128'd0);
        chk("ovf c4 PCWrite", 128'(bus.PCWrite), 128'd0);
        next_cycle();
        drive_idle();
        settle();
        chk("stray ack ExcpCode", 128'(bus.ExcpCode), 128'h2C);

        // -------- InvalidOpcode + jump, DivByZero while busy, MemAck delayed 5 --------
        next_cycle();
        bus.InvalidOpcode = 1'b1; bus.JumpKind = 3'd4;
        settle();
        chk("inv c0 PCWrite", 128'(bus.PCWrite), 128'd0);
        next_cycle();
        drive_idle();
        bus.DivByZero = 1'b1; bus.JumpKind = 3'd1;
        settle();
        chk("inv c1 EPCWrite", 128'(bus.EPCWrite), 128'd1);
        chk("inv c1 PCWrite", 128'(bus.PCWrite), 128'd0);
        begin
            int rd_cycles = 0;
            for (int k = 0; k < 6; k++) begin
                next_cycle();
                drive_idle();
                bus.MemAck  = (k == 5);
                bus.MemData = 8'h91;
                settle();
                if (bus.MemRead === 1'b1) rd_cycles++;
                chk($sformatf("inv fetch%0d ExcpAddr", k), 128'(bus.ExcpAddr), 128'd253);
                chk($sformatf("inv fetch%0d PCWrite", k), 128'(bus.PCWrite), 128'd0);
            end
            chk("inv MemRead cycles", 128'(rd_cycles), 128'd6);
        end
        chk("inv cause kept", 128'(bus.ExcpCause), 128'd1);
        next_cycle();
        drive_idle();
        settle();
        chk("inv c8 PCSrc", 128'(bus.PCSrc), 128'd5);
        chk("inv c8 PCWrite", 128'(bus.PCWrite), 128'd1);
        chk("inv c8 ExcpCode", 128'(bus.ExcpCode), 128'h91);
        chk("inv c8 MemRead", 128'(bus.MemRead), 128'd0);

        // ---------------- reset during FETCH_VEC ----------------
        next_cycle();
        bus.Overflow = 1'b1;
        next_cycle();
        drive_idle();
        next_cycle();
        settle();
        chk("rst pre MemRead", 128'(bus.MemRead), 128'd1);
        reset_n = 1'b0;
        #1;
        chk("rst mid outputs", all_outs(), 128'd0);
        next_cycle();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            settle();
            chk($sformatf("rst post%0d outputs", k), all_outs(), 128'd0);
        end

`ifdef EXCP_TIMEOUT_EN
        // ---------------- timeout with no MemAck ----------------
        next_cycle();
        bus.DivByZero = 1'b1;
        next_cycle();
        drive_idle();
        begin
            int bad_pw = 0;
            for (int k = 0; k < 16; k++) begin
                next_cycle();
                settle();
                if (bus.MemRead !== 1'b1 || bus.PCWrite !== 1'b0) bad_pw++;
            end
            chk("timeout fetch strobes", 128'(bad_pw), 128'd0);
        end
        next_cycle();
        settle();
        chk("timeout Busy", 128'(bus.Busy), 128'd0);
        chk("timeout ExcpErr", 128'(bus.ExcpErr), 128'd1);
        chk("timeout PCWrite", 128'(bus.PCWrite), 128'd0);
`endif

        // ---------------- randomized run against reference model ----------------
        do_reset();
        begin
            int         age = -1;     // cycles since the exception was taken; -1 when idle
            bit         fetched = 0;
            logic [2:0] m_pcsrc = 3'd0;
            logic [7:0] m_code  = 8'd0;
            logic [1:0] m_cause = 2'd0;
            logic       m_err   = 1'b0;
            logic [2:0] e_pcsrc;
            logic       e_pw, e_epcw, e_mr, any;
            logic [31:0] e_addr;
            for (int n = 0; n < 400; n++) begin
                next_cycle();
                bus.JumpKind      = 3'($urandom_range(0, 7));
                bus.BranchTaken   = 1'($urandom_range(0, 1));
                bus.InvalidOpcode = ($urandom_range(0, 7) == 0);
                bus.Overflow      = ($urandom_range(0, 7) == 0);
                bus.DivByZero     = ($urandom_range(0, 7) == 0);
                bus.MemAck        = ($urandom_range(0, 2) == 0);
                bus.MemData       = 8'($urandom);
                settle();
                any = bus.InvalidOpcode | bus.Overflow | bus.DivByZero;
                e_pcsrc = m_pcsrc; e_pw = 0; e_epcw = 0; e_mr = 0; e_addr = 0;
                if (age < 0) begin
                    if (!any) begin
                        case (bus.JumpKind)
                            3'd1: begin e_pcsrc = 3'd0; e_pw = 1; end
                            3'd2: begin e_pcsrc = 3'd1; e_pw = 1; end
                            3'd3: begin e_pcsrc = 3'd3; e_pw = bus.BranchTaken; end
                            3'd4: begin e_pcsrc = 3'd2; e_pw = 1; end
                            3'd5: begin e_pcsrc = 3'd4; e_pw = 1; end
                            default: ;
                        endcase
                    end
                end else if (age == 1) begin
                    e_epcw = 1;
                end else if (!fetched) begin
                    e_mr   = 1;
                    e_addr = 32'd253 + 32'(m_cause) - 32'd1;
                end else begin
                    e_pcsrc = 3'd5; e_pw = 1;
                end
                chk($sformatf("rand cycle %0d", n), all_outs(),
                    {e_pcsrc, e_pw, e_epcw, e_mr, e_addr, 24'd0, m_code,
                     (age >= 0), m_cause, m_err});
                // advance model to the next cycle
                m_pcsrc = e_pcsrc;
                if (age < 0) begin
                    if (any) begin
                        age = 1; fetched = 0;
                        m_cause = prio(bus.InvalidOpcode, bus.Overflow, bus.DivByZero);
                    end
                end else if (age == 1) begin
                    age = 2;
                end else if (!fetched) begin
                    if (bus.MemAck) begin
                        fetched = 1; m_code = bus.MemData; age++;
`ifdef EXCP_TIMEOUT_EN
                    end else if (age - 1 >= 16) begin
                        age = -1; m_err = 1;
`endif
                    end else begin
                        age++;
                    end
                end else begin
                    age = -1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/excp_pc_seq.md
EXCP_PC_SEQ -- requirements
Module: excp_pc_seq

Interface
REQ-001 SHALL have parameter VEC_BASE, default 32'd253, byte address of the first exception-vector byte (InvalidOpcode +0, Overflow +1, DivByZero +2).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16, MemAck wait limit used only when EXCP_TIMEOUT_EN is defined.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; the ports are listed below.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 JumpKind  in  3  PC update request: 0 none, 1 jr, 2 seq (PC+4), 3 branch, 4 j/jal, 5 rte; values 6-7 are treated as none.
REQ-007 BranchTaken  in  1  branch condition, qualified by JumpKind=3.
REQ-008 InvalidOpcode, Overflow, DivByZero  in  1 each  exception request pulses.
REQ-009 MemData  in  8  vector byte from memory.
REQ-010 MemAck  in  1  MemData valid this cycle.
REQ-011 PCSrc  out  3  next-PC selection: 0 RegA, 1 AluResult, 2 IncondJump, 3 AluOut, 4 EPC, 5 ExcpCode.
REQ-012 PCWrite, EPCWrite, MemRead  out  1 each  register and memory strobes.
REQ-013 ExcpAddr  out  32  vector byte address.
REQ-014 ExcpCode  out  32  zero-extended latched vector byte.
REQ-015 Busy  out  1  high whenever the FSM is not in IDLE.
REQ-016 ExcpCause  out  2  last accepted cause: 1 opcode, 2 overflow, 3 div0.
REQ-017 ExcpErr  out  1  sticky timeout flag; held at 0 when EXCP_TIMEOUT_EN is undefined.

Function
REQ-018 FSM states SHALL be IDLE, SAVE_EPC, FETCH_VEC and LOAD_PC.
REQ-019 In IDLE with no exception, outputs SHALL be combinational from JumpKind:
- 1 -> PCSrc=0
- 2 -> PCSrc=1
- 3 -> PCSrc=3, with PCWrite=BranchTaken
- 4 -> PCSrc=2
- 5 -> PCSrc=4
- PCWrite=1 for kinds 1, 2, 4 and 5.
REQ-020 With kind 0 or 6-7, PCWrite SHALL be 0 and PCSrc SHALL hold its last registered value.
REQ-021 Any exception input high in IDLE SHALL win over a simultaneous JumpKind (PCWrite=0 that cycle), latch ExcpCause and move to SAVE_EPC.
REQ-022 Cause priority SHALL be InvalidOpcode > Overflow > DivByZero.
REQ-023 SAVE_EPC SHALL assert EPCWrite=1 for exactly one cycle, then go to FETCH_VEC.
REQ-024 FETCH_VEC SHALL hold MemRead=1 and ExcpAddr=VEC_BASE+cause-1 until MemAck, then latch MemData into ExcpCode and go to LOAD_PC.
REQ-025 LOAD_PC SHALL assert PCSrc=5 and PCWrite=1 for one cycle, then return to IDLE.
REQ-026 Latency from the exception cycle to the PC load SHALL be 3 cycles when MemAck is high on the first FETCH_VEC cycle.
REQ-027 Exception inputs and JumpKind SHALL be ignored while Busy; requests are neither queued nor dropped-flagged.
REQ-028 MemAck outside FETCH_VEC SHALL be ignored.
REQ-029 ExcpAddr SHALL be 0 and MemRead SHALL be 0 outside FETCH_VEC.

Reset
REQ-030 On reset_n low, the FSM SHALL go to IDLE, and PCSrc, ExcpCode, ExcpCause and ExcpErr SHALL clear to 0, with all strobes 0, regardless of the current state.
REQ-031 Reset mid-sequence SHALL abort the sequence; no PCWrite follows reset release without a new request.

Configuration
REQ-032 With EXCP_TIMEOUT_EN defined, a counter SHALL run in FETCH_VEC; after TIMEOUT_CYC cycles without MemAck the FSM SHALL return to IDLE with no PCWrite and set ExcpErr until reset.
REQ-033 With EXCP_TIMEOUT_EN undefined, FETCH_VEC SHALL wait indefinitely and no counter logic SHALL be synthesized.

Structure
REQ-034 A shared package SHALL hold the PCSrc encodings (0-5), JumpKind encodings, cause encodings, VEC_BASE default and FSM state encoding.
REQ-035 The design SHALL be a single module; the optional timeout counter is inline, not a sub-module.

Verification
REQ-036 JumpKind=3, BranchTaken=0 -> PCWrite=0 and PCSrc=3; with BranchTaken=1 -> PCWrite=1.
REQ-037 Overflow and DivByZero both pulse in IDLE, MemAck on the first FETCH_VEC cycle with MemData=8'h2C:
- ExcpCause=2
- EPCWrite high in cycle 1
- ExcpAddr=254 in cycle 2
- PCSrc=5, PCWrite=1 and ExcpCode=32'h2C in cycle 3.
REQ-038 InvalidOpcode pulse with JumpKind=4 in the same cycle -> no PCWrite in that cycle; ExcpAddr=253 in FETCH_VEC.
REQ-039 DivByZero arriving in SAVE_EPC -> ignored; ExcpCause is unchanged.
REQ-040 MemAck delayed 5 cycles -> MemRead is held for 6 cycles and the PC load is 5 cycles later.
REQ-041 reset_n low during FETCH_VEC -> IDLE with all outputs 0.
REQ-042 With EXCP_TIMEOUT_EN defined, no MemAck for 16 cycles -> IDLE and ExcpErr=1 with no PCWrite.
